// File: rtl/fpg8_mem_pkg.sv
`timescale 1ns/1ps
// fpg8_mem_pkg: definitions shared by the memory arbiter slice.
//   - default RAM address/data widths
//   - owner encoding reported on mem_arbiter.owner
//   - arbiter FSM state type and a state-to-owner helper
package fpg8_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 16;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DBG  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_OWN = 2'd1,
    ST_DBG_OWN = 2'd2
  } arb_state_e;

  // The owner code is a direct image of the state that recorded the last grant.
  function automatic logic [1:0] state_to_owner(input arb_state_e st);
    logic [1:0] own;
    case (st)
      ST_CPU_OWN: own = OWN_CPU;
      ST_DBG_OWN: own = OWN_DBG;
      default:    own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/sat_counter.sv
`timescale 1ns/1ps
// sat_counter: small saturating up-counter with synchronous clear.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   inc_i       : count up by one (held at LIMIT once reached)
//   clr_i       : return to zero; wins over inc_i
//   at_limit_o  : count equals LIMIT
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q;

  // Count register: clear has priority, increment stops at LIM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != LIM)) begin
      cnt_q <= cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign at_limit_o = (cnt_q == LIM);

endmodule

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: shares one synchronous single-port RAM between the CPU memory
// path and a debug/loader port. CPU has priority; a starvation counter lets
// debug in after STARVE_LIMIT denied cycles; a bounded lock lets debug keep
// ownership for up to LOCK_MAX extra consecutive grants.
// Ports:
//   clk, reset                         : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt   : CPU request, combinational grant
//   cpu_rvalid, cpu_rdata              : CPU read return (cycle after grant)
//   dbg_req/we/addr/wdata/lock, dbg_gnt, dbg_rvalid, dbg_rdata : debug port
//   ram_w_en/r_en/w_addr/r_addr/w_data : RAM drive (combinational)
//   ram_r_data                         : RAM read data, cycle after ram_r_en
//   owner                              : registered last-granted requester
module mem_arbiter
  import fpg8_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  input  logic                  dbg_lock,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  ram_w_en,
  output logic                  ram_r_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  input  logic [DATA_WIDTH-1:0] ram_r_data,
  output logic [1:0]            owner
);

  arb_state_e state_q, state_d;
  logic [1:0] owner_q;
  logic       cpu_rvalid_q, dbg_rvalid_q;

  logic starve_at_limit, lock_at_limit;
  logic lock_grant, cpu_win, dbg_win;
  logic any_gnt, sel_we;

  // Grant decision: locked debug continuation, then CPU priority with the
  // starvation override, then the sole requester.
  always_comb begin
    lock_grant = 1'b0;
    cpu_win    = 1'b0;
    dbg_win    = 1'b0;
    if ((state_q == ST_DBG_OWN) && dbg_lock && dbg_req && !lock_at_limit) begin
      lock_grant = 1'b1;
      dbg_win    = 1'b1;
    end else if (cpu_req && dbg_req) begin
      if (starve_at_limit) begin
        dbg_win = 1'b1;
      end else begin
        cpu_win = 1'b1;
      end
    end else if (cpu_req) begin
      cpu_win = 1'b1;
    end else if (dbg_req) begin
      dbg_win = 1'b1;
    end else begin
      cpu_win = 1'b0;
    end
  end

  // Grants are suppressed for as long as reset is asserted.
  assign cpu_gnt = cpu_win && !reset;
  assign dbg_gnt = dbg_win && !reset;
  assign any_gnt = cpu_gnt || dbg_gnt;

  // RAM drive: the granted requester's fields, CPU fields when idle.
  always_comb begin
    if (dbg_gnt) begin
      ram_w_addr = dbg_addr;
      ram_w_data = dbg_wdata;
      sel_we     = dbg_we;
    end else begin
      ram_w_addr = cpu_addr;
      ram_w_data = cpu_wdata;
      sel_we     = cpu_we;
    end
  end

  assign ram_r_addr = ram_w_addr;
  assign ram_w_en   = any_gnt && sel_we;
  assign ram_r_en   = any_gnt && !sel_we;

  // Next state records the winner; a cycle without any request goes idle.
  always_comb begin
    if (dbg_gnt) begin
      state_d = ST_DBG_OWN;
    end else if (cpu_gnt) begin
      state_d = ST_CPU_OWN;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // FSM plus registered owner and read-return flags. The rvalid pair acts as
  // the return tag: exactly one is set the cycle after a granted read, and
  // reset drops any read still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= state_to_owner(state_d);
      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      dbg_rvalid_q <= dbg_gnt && !dbg_we;
    end
  end

  assign owner      = owner_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = ram_r_data;
  assign dbg_rdata  = ram_r_data;

  // Starvation: counts denied debug-request cycles; any debug grant or a
  // dropped request restarts the count.
  sat_counter #(
    .WIDTH (4),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk        (clk),
    .rst        (reset),
    .inc_i      (dbg_req && !dbg_gnt),
    .clr_i      (dbg_gnt || !dbg_req),
    .at_limit_o (starve_at_limit)
  );

  // Lock: counts grants won through the lock rule; any other grant or an
  // idle state starts a fresh burst.
  sat_counter #(
    .WIDTH (4),
    .LIMIT (LOCK_MAX)
  ) u_lock_cnt (
    .clk        (clk),
    .rst        (reset),
    .inc_i      (lock_grant && dbg_gnt),
    .clr_i      ((state_q == ST_IDLE) || (any_gnt && !lock_grant)),
    .at_limit_o (lock_at_limit)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural
// 4096x16 synchronous RAM attached to the RAM ports.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [11:0] cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic        ram_w_en, ram_r_en;
  logic [11:0] ram_w_addr, ram_r_addr;
  logic [15:0] ram_w_data;
  logic [15:0] ram_r_data;
  logic [1:0]  owner;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH   (12),
    .DATA_WIDTH   (16),
    .STARVE_LIMIT (4),
    .LOCK_MAX     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .ram_w_en   (ram_w_en),
    .ram_r_en   (ram_r_en),
    .ram_w_addr (ram_w_addr),
    .ram_r_addr (ram_r_addr),
    .ram_w_data (ram_w_data),
    .ram_r_data (ram_r_data),
    .owner      (owner)
  );

  // Behavioural synchronous RAM.
  logic [15:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
  end

  typedef struct {
    logic        cr; logic cw; logic [11:0] ca; logic [15:0] cd;
    logic        dr; logic dw; logic dl; logic [11:0] da; logic [15:0] dd;
    logic        gc; logic gd; logic rvc; logic rvd; logic [15:0] rd;
    logic [1:0]  own;
  } vec_t;

  vec_t vecs [0:12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [11:0] a, input logic [15:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic r, input logic w, input logic l, input logic [11:0] a, input logic [15:0] d);
    dbg_req = r; dbg_we = w; dbg_lock = l; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // row: cpu{req,we,addr,wdata} dbg{req,we,lock,addr,wdata} exp{cgnt,dgnt,crv,drv,rdata,owner}
    vecs[0]  = '{1'b0,1'b0,12'h000,16'h0000, 1'b0,1'b0,1'b0,12'h000,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,2'b00};
    vecs[1]  = '{1'b1,1'b1,12'h005,16'h1234, 1'b0,1'b0,1'b0,12'h000,16'h0000, 1'b1,1'b0,1'b0,1'b0,16'h0000,2'b00};
    vecs[2]  = '{1'b1,1'b0,12'h005,16'h0000, 1'b0,1'b0,1'b0,12'h000,16'h0000, 1'b1,1'b0,1'b0,1'b0,16'h0000,2'b01};
    vecs[3]  = '{1'b0,1'b0,12'h000,16'h0000, 1'b0,1'b0,1'b0,12'h000,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'h1234,2'b01};
    vecs[4]  = '{1'b1,1'b1,12'h000,16'hA5A5, 1'b0,1'b0,1'b0,12'h000,16'h0000, 1'b1,1'b0,1'b0,1'b0,16'h0000,2'b00};
    vecs[5]  = '{1'b0,1'b0,12'h000,16'h0000, 1'b1,1'b1,1'b0,12'hFFF,16'h5A5A, 1'b0,1'b1,1'b0,1'b0,16'h0000,2'b01};
    vecs[6]  = '{1'b0,1'b0,12'h000,16'h0000, 1'b1,1'b0,1'b0,12'h000,16'h0000, 1'b0,1'b1,1'b0,1'b0,16'h0000,2'b10};
    vecs[7]  = '{1'b1,1'b0,12'hFFF,16'h0000, 1'b0,1'b0,1'b0,12'h000,16'h0000, 1'b1,1'b0,1'b0,1'b1,16'hA5A5,2'b10};
    vecs[8]  = '{1'b0,1'b0,12'h000,16'h0000, 1'b0,1'b0,1'b0,12'h000,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'h5A5A,2'b01};
    vecs[9]  = '{1'b0,1'b0,12'h000,16'h0000, 1'b1,1'b1,1'b0,12'h0FF,16'hBEEF, 1'b0,1'b1,1'b0,1'b0,16'h0000,2'b00};
    vecs[10] = '{1'b1,1'b0,12'h0FF,16'h0000, 1'b0,1'b0,1'b0,12'h000,16'h0000, 1'b1,1'b0,1'b0,1'b0,16'h0000,2'b10};
    vecs[11] = '{1'b0,1'b0,12'h000,16'h0000, 1'b0,1'b0,1'b0,12'h000,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'hBEEF,2'b01};
    vecs[12] = '{1'b0,1'b0,12'h000,16'h0000, 1'b0,1'b0,1'b0,12'h000,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,2'b00};

    // Reset with both requesting: nothing may be granted or strobed.
    reset = 1'b1;
    set_cpu(1'b1, 1'b1, 12'h001, 16'h1111);
    set_dbg(1'b1, 1'b1, 1'b0, 12'h002, 16'h2222);
    next_cycle();
    next_cycle();
    #3;
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_dbg_gnt", dbg_gnt, 1'b0);
    chk("rst_ram_w_en", ram_w_en, 1'b0);
    chk("rst_ram_r_en", ram_r_en, 1'b0);
    chk("rst_owner", owner, 2'b00);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
    next_cycle();
    reset = 1'b0;

    // Table: basic traffic, address extremes, write-then-read hazard.
    for (int i = 0; i <= 12; i++) begin
      logic       ew, er;
      logic [11:0] ea;
      logic [15:0] ed;
      set_cpu(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd);
      set_dbg(vecs[i].dr, vecs[i].dw, vecs[i].dl, vecs[i].da, vecs[i].dd);
      ew = (vecs[i].gc && vecs[i].cw) || (vecs[i].gd && vecs[i].dw);
      er = (vecs[i].gc && !vecs[i].cw) || (vecs[i].gd && !vecs[i].dw);
      ea = vecs[i].gd ? vecs[i].da : vecs[i].ca;
      ed = vecs[i].gd ? vecs[i].dd : vecs[i].cd;
      #3;
      chk($sformatf("v%0d_cpu_gnt", i), cpu_gnt, vecs[i].gc);
      chk($sformatf("v%0d_dbg_gnt", i), dbg_gnt, vecs[i].gd);
      chk($sformatf("v%0d_ram_w_en", i), ram_w_en, ew);
      chk($sformatf("v%0d_ram_r_en", i), ram_r_en, er);
      chk($sformatf("v%0d_ram_w_addr", i), ram_w_addr, ea);
      chk($sformatf("v%0d_ram_r_addr", i), ram_r_addr, ea);
      chk($sformatf("v%0d_ram_w_data", i), ram_w_data, ed);
      chk($sformatf("v%0d_cpu_rvalid", i), cpu_rvalid, vecs[i].rvc);
      chk($sformatf("v%0d_dbg_rvalid", i), dbg_rvalid, vecs[i].rvd);
      chk($sformatf("v%0d_owner", i), owner, vecs[i].own);
      if (vecs[i].rvc) chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].rd);
      if (vecs[i].rvd) chk($sformatf("v%0d_dbg_rdata", i), dbg_rdata, vecs[i].rd);
      next_cycle();
    end

    // Continuous contention: CPU x4 then debug, repeating.
    set_cpu(1'b1, 1'b0, 12'h005, 16'h0000);
    set_dbg(1'b1, 1'b0, 1'b0, 12'h0FF, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      #3;
      chk($sformatf("cont%0d_cpu_gnt", i), cpu_gnt, (i % 5) != 4);
      chk($sformatf("cont%0d_dbg_gnt", i), dbg_gnt, (i % 5) == 4);
      chk($sformatf("cont%0d_excl", i), ram_w_en & ram_r_en, 1'b0);
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, 12'h000, 16'h0000);
    set_dbg(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
    next_cycle();

    // Preload 0x100..0x109 through the CPU port.
    for (int i = 0; i < 10; i++) begin
      set_cpu(1'b1, 1'b1, 12'h100 + 12'(i), 16'hC100 + 16'(i));
      #3;
      chk($sformatf("pre%0d_cpu_gnt", i), cpu_gnt, 1'b1);
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, 12'h000, 16'h0000);
    next_cycle();

    // Locked debug burst against a requesting CPU: 9 debug grants, then CPU.
    begin
      int dg;
      dg = 0;
      for (int i = 0; i <= 10; i++) begin
        if (i < 10) begin
          set_cpu(i > 0, 1'b0, 12'h005, 16'h0000);
          set_dbg(1'b1, 1'b0, 1'b1, 12'h100 + 12'(dg), 16'h0000);
        end else begin
          set_cpu(1'b0, 1'b0, 12'h000, 16'h0000);
          set_dbg(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
        end
        #3;
        if (i < 10) begin
          chk($sformatf("lock%0d_dbg_gnt", i), dbg_gnt, i < 9);
          chk($sformatf("lock%0d_cpu_gnt", i), cpu_gnt, i == 9);
        end
        if (i >= 1) begin
          chk($sformatf("lock%0d_dbg_rvalid", i), dbg_rvalid, i <= 9);
          chk($sformatf("lock%0d_cpu_rvalid", i), cpu_rvalid, i == 10);
          if (i <= 9) chk($sformatf("lock%0d_dbg_rdata", i), dbg_rdata, 16'hC100 + 16'(i - 1));
          else        chk("lock_cpu_rdata", cpu_rdata, 16'h1234);
        end
        if (dbg_gnt) dg++;
        next_cycle();
      end
    end

    // Reset the cycle after a CPU read grant: the read is dropped.
    set_cpu(1'b1, 1'b0, 12'h005, 16'h0000);
    #3;
    chk("rmr_grant", cpu_gnt, 1'b1);
    next_cycle();
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 12'h000, 16'h0000);
    set_dbg(1'b1, 1'b0, 1'b0, 12'h0FF, 16'h0000);
    #3;
    chk("rmr_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rmr_dbg_rvalid", dbg_rvalid, 1'b0);
    chk("rmr_owner", owner, 2'b00);
    chk("rmr_cpu_gnt", cpu_gnt, 1'b0);
    chk("rmr_dbg_gnt", dbg_gnt, 1'b0);
    chk("rmr_ram_r_en", ram_r_en, 1'b0);
    next_cycle();
    chk("rmr_cpu_rvalid2", cpu_rvalid, 1'b0);
    reset = 1'b0;
    #3;
    chk("rmr_rel_cpu_gnt", cpu_gnt, 1'b1);
    chk("rmr_rel_dbg_gnt", dbg_gnt, 1'b0);
    chk("rmr_rel_ram_r_en", ram_r_en, 1'b1);
    next_cycle();
    set_cpu(1'b0, 1'b0, 12'h000, 16'h0000);
    set_dbg(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
    #3;
    chk("rmr_rel_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("rmr_rel_cpu_rdata", cpu_rdata, 16'hA5A5);
    chk("rmr_rel_owner", owner, 2'b01);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port 4096×16 RAM between two requesters: the CPU memory path (MAR/MDR strobes from the control unit) and a debug/loader port that preloads or inspects memory. It sits between those requesters and `ram`. The CPU has priority. A saturating starvation counter guarantees debug progress, and a bounded lock lets the debug port run back-to-back bursts. Read data returns one cycle after grant, matching the synchronous RAM read.

## Interface
- `ADDR_WIDTH`, 12, RAM word-address width
- `DATA_WIDTH`, 16, data word width
- `STARVE_LIMIT`, 4, consecutive denied debug-request cycles before debug wins over CPU (1..15)
- `LOCK_MAX`, 8, maximum consecutive locked debug grants before the CPU may preempt (1..15)

Ports:
- `clk` in 1: single clock; `one_shot_clock` in the top level
- `reset` in 1: asynchronous, active-high
- `cpu_req` in 1: CPU requests an access; held until granted
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in ADDR_WIDTH: CPU address (MAR[11:0])
- `cpu_wdata` in DATA_WIDTH: CPU write data (MDR)
- `cpu_gnt` out 1: access performed this cycle
- `cpu_rvalid` out 1: CPU read data valid
- `cpu_rdata` out DATA_WIDTH: read data to MDR
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same meanings, debug port
- `dbg_lock` in 1: debug requests that it keep ownership for the next access
- `ram_w_en` out 1: RAM write strobe
- `ram_r_en` out 1: RAM read strobe
- `ram_w_addr` out ADDR_WIDTH: RAM write address
- `ram_r_addr` out ADDR_WIDTH: RAM read address
- `ram_w_data` out DATA_WIDTH: RAM write data
- `ram_r_data` in DATA_WIDTH: RAM read data, valid the cycle after `ram_r_en`
- `owner` out 2: last granted requester (00 none, 01 CPU, 10 debug)

## Operation
- **FSM states:** IDLE, CPU_OWN, DBG_OWN. The state records the last grant. A cycle with no request returns the FSM to IDLE.
- **Grant decision** is combinational within the cycle, in this priority order:
  1. If state is DBG_OWN, `dbg_lock` = 1, `dbg_req` = 1 and `lock_cnt` < LOCK_MAX: debug wins.
  2. Otherwise, if both request: CPU wins unless `starve_cnt` == STARVE_LIMIT, in which case debug wins.
  3. Otherwise the sole requester wins.
- **Handshake:**
  - An access occurs in the cycle where req && gnt.
  - At most one gnt is high per cycle.
  - A requester holds req, we, addr and wdata stable until granted. The control unit stalls while `cpu_gnt` = 0.
- **RAM drive:**
  - The granted requester's addr drives both `ram_w_addr` and `ram_r_addr`.
  - `ram_w_en` = gnt && we; `ram_r_en` = gnt && !we.
  - When nobody is granted, both strobes are 0 and addr/data hold the CPU inputs.
- **Read return:**
  - A 1-bit registered return tag records the read owner. The matching rvalid is high for exactly one cycle, the cycle after the granted read.
  - `cpu_rdata` and `dbg_rdata` both pass through `ram_r_data`; only rvalid is qualified.
- **starve_cnt** (4 bits):
  - Increments each cycle that `dbg_req` && !`dbg_gnt`, saturating at STARVE_LIMIT.
  - Clears on `dbg_gnt` or !`dbg_req`.
- **lock_cnt** (4 bits):
  - Increments on each debug grant taken via rule 1.
  - Clears on any non-lock grant and in IDLE.
  - At LOCK_MAX the lock is ignored for that cycle.
- **Reset** (any time, including mid-read):
  - State IDLE, both counters 0, return tag cleared, all rvalid 0.
  - gnt and RAM strobes forced 0 while `reset` is high.
  - A pending read is dropped and no rvalid is produced for it.

## Timing
- Grant latency: 0 cycles when uncontested; at most STARVE_LIMIT cycles for debug under continuous CPU traffic.
- Write: RAM updated at the clock edge that ends the grant cycle.
- Read: data and rvalid appear in cycle N+1 for a grant in cycle N. Back-to-back reads give one result per cycle.
- Write to X granted in cycle N followed by a read of X in N+1: the read returns the new data.
- Registered outputs: `owner`, `cpu_rvalid`, `dbg_rvalid`. All of them reset to 0.
- Combinational outputs: gnt and ram_*. They are 0 under reset.

## Structure
- Shared package `fpg8_mem_pkg`:
  - owner encoding constants `OWN_NONE`, `OWN_CPU`, `OWN_DBG`
  - FSM state typedef
  - default ADDR_WIDTH and DATA_WIDTH
- One sub-module `sat_counter` (parameterised limit, inc/clear inputs, at_limit output), instantiated twice: once for starvation, once for lock.

## Test plan
- **CPU-only traffic:** write 0x1234 to 0x005, then read 0x005 → `cpu_gnt` high in both cycles, and `cpu_rvalid` high with `cpu_rdata` = 0x1234 in the cycle after the read.
- **Continuous contention, STARVE_LIMIT = 4:** both request every cycle → CPU granted for 4 cycles, debug on the 5th, and `starve_cnt` returns to 0.
- **Debug locked burst, LOCK_MAX = 8:** 10 reads of 0x100–0x109 with `dbg_lock` = 1 while the CPU requests → debug wins 9 grants (first grant plus 8 locked), then the CPU preempts on the 10th cycle.
- **Write-then-read hazard:** debug writes 0xBEEF to 0x0FF in cycle N, CPU reads 0x0FF in N+1 → `cpu_rdata` = 0xBEEF in N+2 and `dbg_rvalid` stays 0.
- **Reset mid-read:** assert `reset` the cycle after a CPU read grant → `cpu_rvalid` = 0, `owner` = 00, no gnt while `reset` is high, and a normal grant on the first cycle after release.
- **Address extremes:** access 0x000 and 0xFFF → correct data, and `ram_w_en`/`ram_r_en` are never high together.
